// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants: address map, bubble encoding and exception codes.
package mips_defs;

    localparam logic [31:0] PC_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam logic [31:0] IM_LIMIT = 32'(IM_WORDS * 4);
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    // A fetch faults when the PC is not word aligned or runs past the end of instruction memory.
    function automatic logic fetch_addr_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= IM_LIMIT);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Zero-based program counter with asynchronous reset and a hazard-stall hold.
module pc_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic [31:0] i_npc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'h0000_0000;
        end else if (!i_stall) begin
            r_pc <= i_npc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory index and loads the F/D register.
module fetch_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_fd,
    input  logic [31:0] npc_in,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [11:0] im_addr,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_PC8,
    output logic        D_valid,
    output logic        D_exc_adel
);

    logic        w_fetch_err;
    logic [31:0] w_arch_pc;

    pc_reg u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_npc   (npc_in),
        .o_pc    (F_PC)
    );

    assign im_addr     = F_PC[13:2];
    assign w_fetch_err = fetch_addr_err(F_PC);
    assign w_arch_pc   = F_PC + PC_BASE;

    // Stall outranks flush so a bubble never overwrites an instruction Decode is still holding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_instr    <= NOP_WORD;
            D_PC       <= PC_BASE;
            D_PC8      <= PC_BASE + 32'd8;
            D_valid    <= 1'b0;
            D_exc_adel <= 1'b0;
        end else if (!stall) begin
            D_PC  <= w_arch_pc;
            D_PC8 <= w_arch_pc + 32'd8;
            if (flush_fd) begin
                D_instr    <= NOP_WORD;
                D_valid    <= 1'b0;
                D_exc_adel <= 1'b0;
            end else begin
                D_instr    <= w_fetch_err ? NOP_WORD : im_rdata;
                D_valid    <= 1'b1;
                D_exc_adel <= w_fetch_err;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush_fd;
    logic [31:0] npc_in;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic [11:0] im_addr;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic [31:0] D_PC8;
    logic        D_valid;
    logic        D_exc_adel;

    logic [31:0] imem [0:4095];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: architectural view of the PC and the F/D latch.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_dpc;
    logic [31:0] m_dpc8;
    logic        m_valid;
    logic        m_adel;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush_fd   (flush_fd),
        .npc_in     (npc_in),
        .im_rdata   (im_rdata),
        .F_PC       (F_PC),
        .im_addr    (im_addr),
        .D_instr    (D_instr),
        .D_PC       (D_PC),
        .D_PC8      (D_PC8),
        .D_valid    (D_valid),
        .D_exc_adel (D_exc_adel)
    );

    assign im_rdata = imem[im_addr];

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_dpc   = 32'h3000;
        m_dpc8  = 32'h3008;
        m_valid = 1'b0;
        m_adel  = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, settle 1 ns past the edge.
    task automatic cycle(input logic s, input logic f, input logic [31:0] npc);
        logic bad;
        stall    = s;
        flush_fd = f;
        npc_in   = npc;
        @(posedge clk);
        if (!s) begin
            bad    = (m_pc % 4 != 0) || (m_pc >= 32'd16384);
            m_dpc  = m_pc + 32'h3000;
            m_dpc8 = m_pc + 32'h3008;
            if (f) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_adel  = 1'b0;
            end else begin
                m_instr = bad ? 32'h0 : imem[(m_pc / 4) % 4096];
                m_valid = 1'b1;
                m_adel  = bad;
            end
            m_pc = npc;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush_fd = 1'b0; npc_in = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        vectors++; if (F_PC !== 32'h0) begin miscompares++; $display("FAIL reset_fpc: got %h want 0", F_PC); end
        vectors++; if (im_addr !== 12'h0) begin miscompares++; $display("FAIL reset_imaddr: got %h want 0", im_addr); end
        vectors++; if (D_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", D_instr); end
        vectors++; if (D_PC !== 32'h3000) begin miscompares++; $display("FAIL reset_dpc: got %h want 3000", D_PC); end
        vectors++; if (D_PC8 !== 32'h3008) begin miscompares++; $display("FAIL reset_dpc8: got %h want 3008", D_PC8); end
        vectors++; if (D_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", D_valid); end
        vectors++; if (D_exc_adel !== 1'b0) begin miscompares++; $display("FAIL reset_adel: got %b want 0", D_exc_adel); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, m_pc + 32'd4);
            vectors++; if (D_PC !== 32'h3000 + 32'(4 * i)) begin miscompares++; $display("FAIL seq_dpc[%0d]: got %h want %h", i, D_PC, 32'h3000 + 32'(4 * i)); end
            vectors++; if (D_PC8 !== 32'h3008 + 32'(4 * i)) begin miscompares++; $display("FAIL seq_dpc8[%0d]: got %h want %h", i, D_PC8, 32'h3008 + 32'(4 * i)); end
            vectors++; if (D_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b want 1", i, D_valid); end
            vectors++; if (D_instr !== imem[i]) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h want %h", i, D_instr, imem[i]); end
        end
        cycle(1'b0, 1'b0, m_pc + 32'd4);
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        held_instr = m_instr;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, $urandom);
            vectors++; if (F_PC !== 32'h10) begin miscompares++; $display("FAIL stall_fpc[%0d]: got %h want 10", i, F_PC); end
            vectors++; if (D_PC !== 32'h300C) begin miscompares++; $display("FAIL stall_dpc[%0d]: got %h want 300c", i, D_PC); end
            vectors++; if (D_instr !== held_instr) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h want %h", i, D_instr, held_instr); end
        end
        cycle(1'b0, 1'b0, 32'h14);
        vectors++; if (D_PC !== 32'h3010) begin miscompares++; $display("FAIL stall_release_dpc: got %h want 3010", D_PC); end
        vectors++; if (F_PC !== 32'h14) begin miscompares++; $display("FAIL stall_release_fpc: got %h want 14", F_PC); end
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b0, 32'h20);
        cycle(1'b0, 1'b1, 32'h24);
        vectors++; if (D_instr !== 32'h0) begin miscompares++; $display("FAIL flush_instr: got %h want 0", D_instr); end
        vectors++; if (D_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", D_valid); end
        vectors++; if (D_PC !== 32'h3020) begin miscompares++; $display("FAIL flush_dpc: got %h want 3020", D_PC); end
        vectors++; if (D_PC8 !== 32'h3028) begin miscompares++; $display("FAIL flush_dpc8: got %h want 3028", D_PC8); end
        cycle(1'b0, 1'b0, 32'h28);
        cycle(1'b1, 1'b1, 32'h100);
        vectors++; if (D_valid !== 1'b1) begin miscompares++; $display("FAIL flush_stall_valid: got %b want 1", D_valid); end
        vectors++; if (D_PC !== 32'h3024) begin miscompares++; $display("FAIL flush_stall_dpc: got %h want 3024", D_PC); end
        vectors++; if (D_instr !== imem[9]) begin miscompares++; $display("FAIL flush_stall_instr: got %h want %h", D_instr, imem[9]); end
        vectors++; if (F_PC !== 32'h28) begin miscompares++; $display("FAIL flush_stall_fpc: got %h want 28", F_PC); end
    endtask

    task automatic test_adel();
        cycle(1'b0, 1'b0, 32'h4002);
        cycle(1'b0, 1'b0, 32'h4000);
        vectors++; if (D_exc_adel !== 1'b1) begin miscompares++; $display("FAIL adel_mis_flag: got %b want 1", D_exc_adel); end
        vectors++; if (D_instr !== 32'h0) begin miscompares++; $display("FAIL adel_mis_instr: got %h want 0", D_instr); end
        vectors++; if (D_PC !== 32'h7002) begin miscompares++; $display("FAIL adel_mis_dpc: got %h want 7002", D_PC); end
        vectors++; if (D_valid !== 1'b1) begin miscompares++; $display("FAIL adel_mis_valid: got %b want 1", D_valid); end
        vectors++; if (im_addr !== 12'h000) begin miscompares++; $display("FAIL adel_oor_imaddr: got %h want 000", im_addr); end
        cycle(1'b0, 1'b0, 32'h8);
        vectors++; if (D_exc_adel !== 1'b1) begin miscompares++; $display("FAIL adel_oor_flag: got %b want 1", D_exc_adel); end
        vectors++; if (D_instr !== 32'h0) begin miscompares++; $display("FAIL adel_oor_instr: got %h want 0", D_instr); end
        vectors++; if (D_PC !== 32'h7000) begin miscompares++; $display("FAIL adel_oor_dpc: got %h want 7000", D_PC); end
    endtask

    task automatic test_jump();
        cycle(1'b0, 1'b0, 32'h100);
        vectors++; if (F_PC !== 32'h100) begin miscompares++; $display("FAIL jump_fpc: got %h want 100", F_PC); end
        vectors++; if (im_addr !== 12'h040) begin miscompares++; $display("FAIL jump_imaddr: got %h want 040", im_addr); end
        vectors++; if (D_exc_adel !== 1'b0) begin miscompares++; $display("FAIL jump_prev_adel: got %b want 0", D_exc_adel); end
        cycle(1'b0, 1'b0, 32'h104);
        vectors++; if (D_PC !== 32'h3100) begin miscompares++; $display("FAIL jump_dpc: got %h want 3100", D_PC); end
        vectors++; if (D_instr !== imem[12'h040]) begin miscompares++; $display("FAIL jump_instr: got %h want %h", D_instr, imem[12'h040]); end
    endtask

    task automatic test_random();
        logic        s;
        logic        f;
        logic [31:0] npc;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom % 4) == 0;
            f = ($urandom % 6) == 0;
            case ($urandom % 8)
                0:       npc = $urandom;
                1, 2:    npc = 32'($urandom_range(0, 4095)) * 4;
                default: npc = (m_pc + 4 >= 32'd16384) ? 32'h0 : m_pc + 4;
            endcase
            cycle(s, f, npc);
            vectors++; if (F_PC !== m_pc) begin miscompares++; $display("FAIL rnd_fpc[%0d]: got %h want %h", i, F_PC, m_pc); end
            vectors++; if (im_addr !== 12'((m_pc / 4) % 4096)) begin miscompares++; $display("FAIL rnd_imaddr[%0d]: got %h want %h", i, im_addr, 12'((m_pc / 4) % 4096)); end
            vectors++; if (D_instr !== m_instr) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, D_instr, m_instr); end
            vectors++; if (D_PC !== m_dpc) begin miscompares++; $display("FAIL rnd_dpc[%0d]: got %h want %h", i, D_PC, m_dpc); end
            vectors++; if (D_PC8 !== m_dpc8) begin miscompares++; $display("FAIL rnd_dpc8[%0d]: got %h want %h", i, D_PC8, m_dpc8); end
            vectors++; if (D_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, D_valid, m_valid); end
            vectors++; if (D_exc_adel !== m_adel) begin miscompares++; $display("FAIL rnd_adel[%0d]: got %b want %b", i, D_exc_adel, m_adel); end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 32'h40);
        cycle(1'b0, 1'b1, 32'h44);
        stall    = 1'b1;
        flush_fd = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++; if (F_PC !== 32'h0) begin miscompares++; $display("FAIL areset_fpc: got %h want 0", F_PC); end
        vectors++; if (D_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b want 0", D_valid); end
        vectors++; if (D_PC !== 32'h3000) begin miscompares++; $display("FAIL areset_dpc: got %h want 3000", D_PC); end
        vectors++; if (D_PC8 !== 32'h3008) begin miscompares++; $display("FAIL areset_dpc8: got %h want 3008", D_PC8); end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'h4);
        vectors++; if (D_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_valid: got %b want 1", D_valid); end
        vectors++; if (D_PC !== 32'h3000) begin miscompares++; $display("FAIL post_reset_dpc: got %h want 3000", D_PC); end
        vectors++; if (D_instr !== imem[0]) begin miscompares++; $display("FAIL post_reset_instr: got %h want %h", D_instr, imem[0]); end
        vectors++; if (F_PC !== 32'h4) begin miscompares++; $display("FAIL post_reset_fpc: got %h want 4", F_PC); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = $urandom | 32'h1;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_adel();
        test_jump();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Holds the program counter and the F/D pipeline register of the 5-stage MIPS pipeline.
- Consumes the next-PC value produced by the next-PC logic, drives the instruction-memory address, and registers the fetched word, PC and link address into Decode.
- Internal PC is zero-based: the architectural address is PC + PC_BASE.
- Handles load-use stalls and F/D flush; detects fetch address errors (AdEL).

Parameters:
- PC_BASE, 32'h0000_3000, architectural address of internal PC 0.
- IM_WORDS, 4096, instruction-memory depth in words; fetch index range is 0 .. IM_WORDS*4-4.
- NOP_WORD, 32'h0000_0000, bubble instruction inserted on flush or fetch error.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall: hold PC and F/D.
- flush_fd  input  1  replace F/D contents with a bubble.
- npc_in  input  32  zero-based next PC from the next-PC logic.
- im_rdata  input  32  combinational instruction-memory read data for im_addr.
- F_PC  output  32  current zero-based PC (fed back to the next-PC logic).
- im_addr  output  12  word index into instruction memory, F_PC[13:2].
- D_instr  output  32  registered instruction.
- D_PC  output  32  registered architectural PC (zero-based PC + PC_BASE).
- D_PC8  output  32  registered link address, D_PC + 8.
- D_valid  output  1  F/D holds a real instruction.
- D_exc_adel  output  1  registered fetch address error for the instruction in F/D.

Behaviour:
- Reset (async, immediate):
  - PC = 0.
  - D_instr = NOP_WORD, D_PC = PC_BASE, D_PC8 = PC_BASE + 8.
  - D_valid = 0, D_exc_adel = 0.
- PC register:
  - Each rising edge with stall = 0: PC <= npc_in.
  - With stall = 1: PC holds.
  - No internal +4: sequential advance comes entirely from npc_in.
- Fetch error:
  - Asserted combinationally when F_PC[1:0] != 0 or F_PC >= IM_WORDS*4.
  - im_addr is still driven as F_PC[13:2]; memory data is ignored.
- F/D register, priority stall > flush_fd > load:
  - stall = 1: all F/D outputs hold, even if flush_fd = 1 in the same cycle.
  - stall = 0, flush_fd = 1: D_instr = NOP_WORD, D_valid = 0, D_exc_adel = 0. D_PC / D_PC8 take the current fetch PC so exception EPC tracking stays monotonic.
  - stall = 0, flush_fd = 0 (normal load):
    - D_instr = fetch error ? NOP_WORD : im_rdata.
    - D_PC = F_PC + PC_BASE; D_PC8 = F_PC + PC_BASE + 8.
    - D_valid = 1; D_exc_adel = fetch error.
- Latency: the instruction at PC n appears on D_* one edge after PC = n, given no stall.
- Arithmetic: 32-bit unsigned, wrap-around discarded, no overflow flag.
- Post-reset: the first edge after reset deassertion loads the instruction at PC 0 (D_valid = 1). PC 0 is never skipped.
- Reset asserted mid-stall or mid-flush: reset wins immediately; no pending state survives.
- Stall held for N cycles: PC and F/D unchanged for N edges; npc_in is ignored throughout.

Decomposition:
- Shared package `mips_defs`: PC_BASE, NOP_WORD, IM_WORDS, and the exception code constant EXC_ADEL = 5'd4 used by later stages.
- One natural sub-module: `pc_reg`, holding the PC flop with async reset and stall enable.
- Fetch-error logic and the F/D register stay in fetch_stage.

Test Plan:
- Reset then sequential npc_in = F_PC + 4 for 3 edges -> D_PC = 0x3000, 0x3004, 0x3008; D_PC8 = 0x3008, 0x300C, 0x3010; D_valid = 1 from the first edge.
- Stall for 2 cycles with F_PC = 0x10 -> F_PC stays 0x10; D_instr/D_PC (0x300C) unchanged; releases to D_PC = 0x3010 on the next edge.
- flush_fd = 1 with stall = 0 at F_PC = 0x20 -> D_instr = 0, D_valid = 0, D_PC = 0x3020. Same cycle with stall = 1 -> F/D unchanged.
- npc_in = 0x4002 (misaligned), then npc_in = 0x4000 (equals IM_WORDS*4, out of range) -> D_exc_adel = 1 and D_instr = 0 on each; D_PC = 0x7002 and 0x7000.
- Jump npc_in = 0x0100 from F_PC = 0x0008 -> next F_PC = 0x0100, im_addr = 0x040; following edge D_PC = 0x3100.
- Assert reset asynchronously between edges during a stall -> all outputs take reset values immediately: F_PC = 0, D_valid = 0.
